// File: rtl/alu.sv
// Multi-cycle W-bit integer ALU: add/sub in one step, shift-add / Booth multiply over W steps.
// Define ALU_DIV_EN to include the W-step restoring divider for operator 5'h04.
module alu #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     dtype,
  input  logic [4:0]     operator,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  input  logic           parser_done,
  output logic           alu_done,
  output logic [2*W-1:0] calc_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam int CW = $clog2(W + 1);

  logic [1:0]     state_q, state_d;
  logic           pd_prev_q, pd_prev_d;
  logic [4:0]     op_q, op_d;
  logic           sgn_q, sgn_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   m_q, m_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] res_q, res_d;
  logic           done_q, done_d;

  logic           iter_op;
  logic [2*W-1:0] ext_a, ext_b;
  logic [W:0]     m_ext, mul_sum, mul_acc_nx;
  logic [W-1:0]   mul_q_nx;

  assign alu_done = done_q;
  assign calc_res = res_q;

  assign ext_a = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign ext_b = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};

`ifdef ALU_DIV_EN
  logic [W-1:0]   in_a_mag, in_b_mag;
  logic [W:0]     div_shift, div_trial, div_acc_nx;
  logic [W-1:0]   div_q_nx, div_quo, div_rem;
  logic [2*W-1:0] div_res;

  assign iter_op  = (op_q == OP_MUL) || (op_q == OP_DIV);
  // Signed divide runs on magnitudes; signs are restored when the result is formed.
  assign in_a_mag = (dtype == 4'h1 && src1[W-1]) ? -src1 : src1;
  assign in_b_mag = (dtype == 4'h1 && src2[W-1]) ? -src2 : src2;

  always_comb begin
    div_shift = {acc_q[W-1:0], q_q[W-1]};
    div_trial = div_shift - {1'b0, m_q};
    if (!div_trial[W]) begin
      div_acc_nx = div_trial;
      div_q_nx   = {q_q[W-2:0], 1'b1};
    end else begin
      div_acc_nx = div_shift;
      div_q_nx   = {q_q[W-2:0], 1'b0};
    end
    div_quo = (sgn_q && (a_q[W-1] ^ b_q[W-1])) ? -q_q : q_q;
    div_rem = (sgn_q && a_q[W-1]) ? -acc_q[W-1:0] : acc_q[W-1:0];
    div_res = (b_q == '0) ? '1 : {div_rem, div_quo};
  end
`else
  assign iter_op = (op_q == OP_MUL);
`endif

  // One multiply step: Booth recoding when signed, plain shift-add when unsigned.
  always_comb begin
    m_ext   = sgn_q ? {m_q[W-1], m_q} : {1'b0, m_q};
    mul_sum = acc_q;
    if (sgn_q) begin
      if (q_q[0] && !qm1_q)
        mul_sum = acc_q - m_ext;
      else if (!q_q[0] && qm1_q)
        mul_sum = acc_q + m_ext;
    end else if (q_q[0]) begin
      mul_sum = acc_q + m_ext;
    end
    mul_acc_nx = {sgn_q & mul_sum[W], mul_sum[W:1]};
    mul_q_nx   = {mul_sum[0], q_q[W-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    pd_prev_d = parser_done;
    op_d      = op_q;
    sgn_d     = sgn_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (parser_done && !pd_prev_q) begin
          op_d    = operator;
          sgn_d   = (dtype == 4'h1);
          a_d     = src1;
          b_d     = src2;
          m_d     = src2;
          q_d     = src1;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef ALU_DIV_EN
          if (operator == OP_DIV) begin
            q_d = in_a_mag;
            m_d = in_b_mag;
          end
`endif
        end
      end
      S_CALC: begin
        if (!iter_op) begin
          case (op_q)
            OP_ADD:  res_d = ext_a + ext_b;
            OP_SUB:  res_d = ext_a - ext_b;
            default: res_d = '0;
          endcase
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != CW'(W)) begin
          cnt_d = cnt_q + 1'b1;
          acc_d = mul_acc_nx;
          q_d   = mul_q_nx;
          qm1_d = q_q[0];
`ifdef ALU_DIV_EN
          if (op_q == OP_DIV) begin
            acc_d = div_acc_nx;
            q_d   = div_q_nx;
          end
`endif
        end else begin
          res_d = {acc_q[W-1:0], q_q};
`ifdef ALU_DIV_EN
          if (op_q == OP_DIV)
            res_d = div_res;
`endif
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pd_prev_q <= 1'b0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pd_prev_q <= pd_prev_d;
      op_q      <= op_d;
      sgn_q     <= sgn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed and random ops against an arithmetic reference model.
module tb_alu;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     dtype;
  logic [4:0]     operator;
  logic [W-1:0]   src1, src2;
  logic           parser_done;
  logic           alu_done;
  logic [2*W-1:0] calc_res;

  int n_checks = 0;
  int n_pass   = 0;

  alu #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dtype       (dtype),
    .operator    (operator),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .alu_done    (alu_done),
    .calc_res    (calc_res)
  );

  always #5 clk = ~clk;

  function automatic bit div_enabled();
`ifdef ALU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: extend to wide integers, apply the operator with ordinary arithmetic, keep 32 bits.
  function automatic logic [31:0] model(input logic [3:0] dt, input logic [4:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    longint ea, eb, r, qv, rv;
    bit s;
    s  = (dt == 4'h1);
    ea = s ? longint'($signed(a)) : longint'(a);
    eb = s ? longint'($signed(b)) : longint'(b);
    r  = 0;
    case (op)
      5'h01: r = ea + eb;
      5'h02: r = ea - eb;
      5'h03: r = ea * eb;
      5'h04: begin
        if (div_enabled()) begin
          if (b == 16'h0) begin
            r = 64'hFFFF_FFFF;
          end else begin
            qv = ea / eb;
            rv = ea % eb;
            r  = {32'h0, rv[15:0], qv[15:0]};
          end
        end
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // One transaction: raise parser_done, scramble inputs after the latch edge,
  // drop parser_done after 'hold' cycles, watch for alu_done pulses.
  task automatic do_op(input logic [3:0] dt, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int hold, input bit reraise, input string tag);
    logic [31:0] exp, got;
    int lat, pulses, exp_lat;
    exp     = model(dt, op, a, b);
    exp_lat = (op == 5'h03 || (op == 5'h04 && div_enabled())) ? W + 2 : 2;
    lat = 0; pulses = 0; got = '0;
    @(negedge clk);
    dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        dtype = 4'($urandom); operator = 5'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
      end
      if (c == hold) parser_done = 1'b0;
      if (reraise && c == 5) parser_done = 1'b1;
      if (reraise && c == 7) parser_done = 1'b0;
      if (alu_done) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          got = calc_res;
        end
      end
    end
    parser_done = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".res"}, got, exp);
    check({tag, ".held"}, calc_res, exp);
    $display("op %s dt=%0h op=%0h a=%04h b=%04h -> res=%08h lat=%0d pulses=%0d (exp %08h)",
             tag, dt, op, a, b, got, lat, pulses, exp);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; parser_done = 1'b0; dtype = '0; operator = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    check("reset.done", 32'(alu_done), 32'd0);
    check("reset.res", calc_res, 32'd0);
    rst = 1'b0;

    do_op(4'h2, 5'h01, 16'd7, 16'd2, 3, 1'b0, "add_u");
    do_op(4'h1, 5'h02, 16'd8, 16'd4, 3, 1'b0, "sub_s");
    do_op(4'h1, 5'h02, 16'd2, 16'd5, 3, 1'b0, "sub_s_neg");
    do_op(4'h2, 5'h02, 16'd2, 16'd5, 3, 1'b0, "sub_u_wrap");
    do_op(4'h2, 5'h01, 16'hFFFF, 16'hFFFF, 3, 1'b0, "add_u_carry");
    do_op(4'h2, 5'h03, 16'd7, 16'd3, 10, 1'b0, "mul_u");
    do_op(4'h1, 5'h03, 16'h0006, 16'hFFFB, 20, 1'b0, "mul_booth");
    do_op(4'h1, 5'h03, 16'h8000, 16'h8000, 2, 1'b0, "mul_s_min");
    do_op(4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 2, 1'b0, "mul_u_max");
    do_op(4'h2, 5'h03, 16'd9, 16'd11, 20, 1'b1, "mul_busy_rise");
    do_op(4'h2, 5'h04, 16'd17, 16'd5, 2, 1'b0, "div_u");
    do_op(4'h2, 5'h04, 16'd17, 16'd0, 2, 1'b0, "div_zero");
    do_op(4'h1, 5'h04, 16'hFFEF, 16'd5, 2, 1'b0, "div_s");
    do_op(4'h1, 5'h04, 16'h8000, 16'hFFFF, 2, 1'b0, "div_s_min");
    do_op(4'h2, 5'h1F, 16'd3, 16'd4, 2, 1'b0, "invalid");

    // Reset in the middle of a multiply: aborted, no pulse, result cleared.
    @(negedge clk);
    dtype = 4'h2; operator = 5'h03; src1 = 16'd100; src2 = 16'd200; parser_done = 1'b1;
    repeat (3) @(negedge clk);
    parser_done = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (alu_done) pulses++;
    end
    check("rst_mid.pulses", 32'(pulses), 32'd0);
    check("rst_mid.res", calc_res, 32'd0);
    $display("op rst_mid_mul -> res=%08h pulses=%0d", calc_res, pulses);
    do_op(4'h2, 5'h03, 16'd100, 16'd200, 4, 1'b0, "mul_after_rst");

    // Reset and a parser_done rise on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; parser_done = 1'b1; dtype = 4'h2; operator = 5'h01; src1 = 16'd1; src2 = 16'd1;
    @(negedge clk);
    rst = 1'b0; parser_done = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (alu_done) pulses++;
    end
    check("rst_rise.pulses", 32'(pulses), 32'd0);
    check("rst_rise.res", calc_res, 32'd0);
    $display("op rst_and_rise -> res=%08h pulses=%0d", calc_res, pulses);

    for (int i = 0; i < 30; i++) begin
      logic [3:0]  dt;
      logic [4:0]  op;
      logic [15:0] a, b;
      dt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'h1 : 4'h2);
      op = 5'($urandom_range(0, 6));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      do_op(dt, op, a, b, $urandom_range(1, 25), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
